// File: rtl/m6502_rdy_sched_if.sv
// Front-panel request and CPU bus bundle for the 6502 RDY scheduler.
// master drives requests/bus status, slave is the scheduler.
interface m6502_rdy_sched_if #(
  parameter int STEP_W = 8
);
  logic              RUN_REQ;
  logic              SC_REQ;
  logic              SI_REQ;
  logic              NS_REQ;
  logic [STEP_W-1:0] NS_COUNT;
  logic              SYNC;
  logic              W_N;
  logic              RDY;
  logic              HALTED;
  logic [1:0]        STATE;
  logic [STEP_W-1:0] STEPS_LEFT;

  modport master (
    output RUN_REQ, SC_REQ, SI_REQ, NS_REQ,
    output NS_COUNT, SYNC, W_N,
    input  RDY, HALTED, STATE, STEPS_LEFT
  );

  modport slave (
    input  RUN_REQ, SC_REQ, SI_REQ, NS_REQ,
    input  NS_COUNT, SYNC, W_N,
    output RDY, HALTED, STATE, STEPS_LEFT
  );
endinterface

// File: rtl/m6502_rdy_sched.sv
// 6502 RDY scheduler: run/halt, single-cycle, single- and N-instruction
// stepping, halting only on opcode fetches or after one bus cycle.
module m6502_rdy_sched #(
  parameter int STEP_W = 8
) (
  input  logic               PHI2,
  input  logic               RESET_N,
  m6502_rdy_sched_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_CYCLE = 2'b11
  } st_t;

  localparam logic [STEP_W-1:0] ONE = 1;

  st_t               r_state;
  st_t               w_nxt;
  logic [STEP_W-1:0] r_cnt;
  logic [STEP_W-1:0] w_nxt_cnt;
  logic              r_halted;
  logic              r_sc_q;
  logic              r_si_q;
  logic              r_ns_q;
  logic              w_sc_e;
  logic              w_si_e;
  logic              w_ns_e;
  logic              w_ns_ok;
  logic              w_cnt_z;
  logic              w_rdy;

  assign w_sc_e  = bus.SC_REQ & ~r_sc_q;
  assign w_si_e  = bus.SI_REQ & ~r_si_q;
  assign w_ns_e  = bus.NS_REQ & ~r_ns_q;
  assign w_ns_ok = w_ns_e & (bus.NS_COUNT != '0);
  assign w_cnt_z = (r_cnt == '0);

  always_comb begin
    w_nxt     = r_state;
    w_nxt_cnt = r_cnt;
    if (bus.RUN_REQ) begin
      w_nxt     = ST_RUN;
      w_nxt_cnt = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          w_nxt     = ST_DRAIN;
          w_nxt_cnt = '0;
        end
        ST_CYCLE: w_nxt = ST_HALT;
        ST_HALT: begin
          if (w_ns_ok) begin
            w_nxt     = ST_DRAIN;
            w_nxt_cnt = bus.NS_COUNT;
          end else if (w_si_e) begin
            w_nxt     = ST_DRAIN;
            w_nxt_cnt = ONE;
          end else if (w_sc_e) begin
            w_nxt     = ST_CYCLE;
          end
        end
        ST_DRAIN: begin
          // each fetch let through retires one step; zero holds the fetch
          if (bus.SYNC) begin
            if (w_cnt_z) w_nxt     = ST_HALT;
            else         w_nxt_cnt = r_cnt - ONE;
          end
        end
      endcase
    end
  end

  always_ff @(negedge PHI2) begin
    if (!RESET_N) begin
      r_state  <= ST_DRAIN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_sc_q   <= 1'b1;
      r_si_q   <= 1'b1;
      r_ns_q   <= 1'b1;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_nxt_cnt;
      r_halted <= (w_nxt == ST_HALT);
      r_sc_q   <= bus.SC_REQ;
      r_si_q   <= bus.SI_REQ;
      r_ns_q   <= bus.NS_REQ;
    end
  end

  // writes are never stalled; a halted read is held until released
  always_comb begin
    w_rdy = 1'b1;
    if (RESET_N) begin
      case (r_state)
        ST_HALT:  w_rdy = ~bus.W_N;
        ST_DRAIN: w_rdy = ~w_cnt_z | ~bus.SYNC | ~bus.W_N;
        default:  w_rdy = 1'b1;
      endcase
    end
  end

  assign bus.RDY        = w_rdy;
  assign bus.HALTED     = r_halted;
  assign bus.STATE      = r_state;
  assign bus.STEPS_LEFT = r_cnt;
endmodule

// File: tb/tb_m6502_rdy_sched.sv
// Bench for m6502_rdy_sched: vector table, directed corner sequences
// and random stimulus against a behavioural model.
module tb_m6502_rdy_sched;
  localparam int W       = 8;
  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_CYC   = 3;

  logic PHI2 = 1'b1;
  logic RESET_N;

  m6502_rdy_sched_if #(.STEP_W(W)) bus();

  m6502_rdy_sched #(.STEP_W(W)) dut (
    .PHI2    (PHI2),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 PHI2 = ~PHI2;

  typedef struct {
    bit run, sc, si, ns;
    int nsc;
    bit sync, wn;
    bit rdy;
    int st;
    int cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_st;
  int   m_cnt;
  bit   p_sc, p_si, p_ns;
  bit   chk_en;

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic bit model_rdy();
    if (!RESET_N) return 1'b1;
    if (m_st == M_RUN || m_st == M_CYC) return 1'b1;
    if (!bus.W_N) return 1'b1;
    if (m_st == M_DRAIN)
      return (m_cnt > 0) || !bus.SYNC;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit e_sc, e_si, e_ns;
    if (!RESET_N) begin
      m_st = M_DRAIN; m_cnt = 0;
      p_sc = 1; p_si = 1; p_ns = 1;
      return;
    end
    e_sc = bus.SC_REQ && !p_sc;
    e_si = bus.SI_REQ && !p_si;
    e_ns = bus.NS_REQ && !p_ns;
    p_sc = bus.SC_REQ;
    p_si = bus.SI_REQ;
    p_ns = bus.NS_REQ;
    if (bus.RUN_REQ) begin
      m_st = M_RUN; m_cnt = 0;
    end else if (m_st == M_RUN) begin
      m_st = M_DRAIN; m_cnt = 0;
    end else if (m_st == M_CYC) begin
      m_st = M_HALT;
    end else if (m_st == M_HALT) begin
      if (e_ns && bus.NS_COUNT != 0) begin
        m_st = M_DRAIN; m_cnt = int'(bus.NS_COUNT);
      end else if (e_si) begin
        m_st = M_DRAIN; m_cnt = 1;
      end else if (e_sc) begin
        m_st = M_CYC;
      end
    end else if (bus.SYNC) begin
      if (m_cnt == 0) m_st = M_HALT;
      else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic drv(bit run, bit sc, bit si, bit ns,
                     int nsc, bit sync, bit wn);
    bus.RUN_REQ  = run;
    bus.SC_REQ   = sc;
    bus.SI_REQ   = si;
    bus.NS_REQ   = ns;
    bus.NS_COUNT = nsc[W-1:0];
    bus.SYNC     = sync;
    bus.W_N      = wn;
  endtask

  task automatic settle();
    #1;
    if (chk_en) begin
      check("m_rdy", 32'(bus.RDY), 32'(model_rdy()));
      check("m_state", 32'(bus.STATE), m_st);
      check("m_halted", 32'(bus.HALTED),
            32'(m_st == M_HALT));
      check("m_steps", 32'(bus.STEPS_LEFT), m_cnt);
    end
  endtask

  task automatic edge_();
    @(negedge PHI2);
    model_edge();
    @(posedge PHI2);
  endtask

  task automatic cyc();
    settle();
    edge_();
  endtask

  task automatic add(bit run, bit sc, bit si, bit ns, int nsc,
                     bit sync, bit wn, bit rdy, int st, int cnt);
    vec_t v;
    v.run = run; v.sc = sc; v.si = si; v.ns = ns;
    v.nsc = nsc; v.sync = sync; v.wn = wn;
    v.rdy = rdy; v.st = st; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    // reset sequence, then SYNC halts
    for (int i = 0; i < 7; i++)
      add(0,0,0,0,0, 0,1, 1,M_DRAIN,0);
    add(0,0,0,0,0, 1,1, 0,M_DRAIN,0);
    add(0,0,0,0,0, 1,1, 0,M_HALT,0);
    // single instruction: fetch + 2 operands
    add(0,0,1,0,0, 1,1, 0,M_HALT,0);
    add(0,0,1,0,0, 1,1, 1,M_DRAIN,1);
    add(0,0,0,0,0, 0,1, 1,M_DRAIN,0);
    add(0,0,0,0,0, 0,1, 1,M_DRAIN,0);
    add(0,0,0,0,0, 1,1, 0,M_DRAIN,0);
    add(0,0,0,0,0, 1,1, 0,M_HALT,0);
    // N-step of 5
    add(0,0,0,1,5, 1,1, 0,M_HALT,0);
    for (int k = 5; k >= 1; k--) begin
      add(0,0,0,1,5, 1,1, 1,M_DRAIN,k);
      add(0,0,0,1,5, 0,1, 1,M_DRAIN,k-1);
    end
    add(0,0,0,1,5, 1,1, 0,M_DRAIN,0);
    add(0,0,0,1,5, 1,1, 0,M_HALT,0);
    add(0,0,0,0,0, 1,1, 0,M_HALT,0);
    // N-step of 0 ignored
    add(0,0,0,1,0, 1,1, 0,M_HALT,0);
    add(0,0,0,1,0, 1,1, 0,M_HALT,0);
    add(0,0,0,0,0, 1,1, 0,M_HALT,0);
    // single cycle
    add(0,1,0,0,0, 1,1, 0,M_HALT,0);
    add(0,1,0,0,0, 1,1, 1,M_CYC,0);
    add(0,1,0,0,0, 0,1, 0,M_HALT,0);
    // halted on writes
    add(0,0,0,0,0, 0,0, 1,M_HALT,0);
    add(0,0,0,0,0, 0,0, 1,M_HALT,0);
    add(0,0,0,0,0, 0,1, 0,M_HALT,0);
    add(1,0,0,0,0, 0,1, 0,M_HALT,0);
    add(1,0,0,0,0, 0,1, 1,M_RUN,0);

    chk_en  = 0;
    RESET_N = 0;
    drv(0,0,0,0,0, 0,1);
    m_st = M_DRAIN; m_cnt = 0;
    p_sc = 1; p_si = 1; p_ns = 1;
    @(posedge PHI2);
    chk_en = 1;
    settle();
    check("rst_rdy", 32'(bus.RDY), 1);
    check("rst_state", 32'(bus.STATE), M_DRAIN);
    edge_();
    RESET_N = 1;

    foreach (tbl[i]) begin
      drv(tbl[i].run, tbl[i].sc, tbl[i].si, tbl[i].ns,
          tbl[i].nsc, tbl[i].sync, tbl[i].wn);
      settle();
      check($sformatf("t%0d_rdy", i), 32'(bus.RDY),
            32'(tbl[i].rdy));
      check($sformatf("t%0d_state", i), 32'(bus.STATE),
            tbl[i].st);
      check($sformatf("t%0d_steps", i), 32'(bus.STEPS_LEFT),
            tbl[i].cnt);
      edge_();
    end

    // run 20 cycles, drop mid-instruction
    for (int i = 0; i < 20; i++) begin
      drv(1,0,0,0,0, (i % 3) == 1, 1);
      settle();
      check("run_rdy", 32'(bus.RDY), 1);
      edge_();
    end
    drv(0,0,0,0,0, 0,1);
    settle();
    check("drop_rdy0", 32'(bus.RDY), 1);
    edge_();
    settle();
    check("drop_rdy1", 32'(bus.RDY), 1);
    check("drop_st1", 32'(bus.STATE), M_DRAIN);
    edge_();
    drv(0,0,0,0,0, 1,1);
    settle();
    check("drop_rdy2", 32'(bus.RDY), 0);
    edge_();
    settle();
    check("drop_halt", 32'(bus.HALTED), 1);
    edge_();

    // RUN_REQ aborts an N=3 step
    drv(0,0,0,1,3, 1,1); cyc();
    drv(0,0,0,1,3, 1,1); cyc();
    drv(0,0,0,1,3, 0,1); cyc();
    drv(1,0,0,1,3, 1,1);
    settle();
    check("ab_steps0", 32'(bus.STEPS_LEFT), 2);
    edge_();
    drv(1,0,0,1,3, 0,1);
    settle();
    check("ab_state", 32'(bus.STATE), M_RUN);
    check("ab_steps", 32'(bus.STEPS_LEFT), 0);
    edge_();
    drv(0,0,0,0,0, 1,1); cyc();
    drv(0,0,0,0,0, 1,1); cyc();
    settle();
    check("ab_halt", 32'(bus.STATE), M_HALT);
    edge_();

    // simultaneous SC/SI/NS edges, NS_COUNT=2
    drv(0,1,1,1,2, 1,1); cyc();
    for (int k = 2; k >= 0; k--) begin
      settle();
      check("sim_state", 32'(bus.STATE), M_DRAIN);
      check("sim_steps", 32'(bus.STEPS_LEFT), k);
      check("sim_rdy", 32'(bus.RDY), 32'(k != 0));
      edge_();
    end
    settle();
    check("sim_halt", 32'(bus.STATE), M_HALT);
    edge_();

    // reset mid-drain
    drv(0,0,0,0,0, 1,1); cyc();
    drv(0,0,0,1,4, 1,1); cyc();
    cyc();
    RESET_N = 0;
    settle();
    check("mr_rdy0", 32'(bus.RDY), 1);
    edge_();
    settle();
    check("mr_state", 32'(bus.STATE), M_DRAIN);
    check("mr_steps", 32'(bus.STEPS_LEFT), 0);
    check("mr_rdy1", 32'(bus.RDY), 1);
    edge_();
    RESET_N = 1;
    drv(0,0,0,0,0, 1,1);
    settle();
    check("mr_hold", 32'(bus.RDY), 0);
    edge_();

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      RESET_N = ($urandom_range(0, 199) != 0);
      drv(($urandom_range(0, 19) == 0) ^ bus.RUN_REQ,
          ($urandom_range(0, 3) == 0) ^ bus.SC_REQ,
          ($urandom_range(0, 3) == 0) ^ bus.SI_REQ,
          ($urandom_range(0, 3) == 0) ^ bus.NS_REQ,
          int'($urandom_range(0, 6)),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
